// File: rtl/display_pkg.sv
// Shared constants, conversion FSM states and value saturation for the
// multiplexed 7448 display scan driver.
package display_pkg;

    localparam int NUM_DIGITS  = 4;
    localparam int VALUE_W     = 14;
    localparam int BCD_MAX     = 9999;
    localparam int SHIFT_STEPS = 14;
    localparam int BCD_W       = 4 * NUM_DIGITS;
    localparam int STEP_W      = $clog2(SHIFT_STEPS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } conv_state_t;

    // Four BCD digits cannot show more than 9999, so larger counts clamp.
    function automatic logic [VALUE_W-1:0] saturate(input logic [VALUE_W-1:0] v);
        return (32'(v) > 32'(BCD_MAX)) ? VALUE_W'(BCD_MAX) : v;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per clock.
// done pulses for one cycle while bcd holds the finished result.
//
// state  | meaning
// IDLE   | waiting for start; bin is captured on the start edge
// SHIFT  | one double-dabble step per edge, SHIFT_STEPS edges in total
// COMMIT | result valid on bcd with done=1; returns to IDLE next edge
module bin2bcd_seq
    import display_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [VALUE_W-1:0] bin,
    output logic [BCD_W-1:0]   bcd,
    output logic               done
);

    localparam int SR_W = BCD_W + VALUE_W;

    conv_state_t       state;
    logic [SR_W-1:0]   sr;
    logic [STEP_W-1:0] steps_left;

    function automatic logic [SR_W-1:0] dabble(input logic [SR_W-1:0] s);
        logic [SR_W-1:0] t;
        t = s;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (t[VALUE_W + 4*i +: 4] >= 4'd5)
                t[VALUE_W + 4*i +: 4] = t[VALUE_W + 4*i +: 4] + 4'd3;
        end
        return t << 1;
    endfunction

    assign bcd = sr[SR_W-1 -: BCD_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sr         <= '0;
            steps_left <= '0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sr         <= {BCD_W'(0), bin};
                        steps_left <= STEP_W'(SHIFT_STEPS);
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr         <= dabble(sr);
                    steps_left <= steps_left - 1'b1;
                    if (steps_left == STEP_W'(1)) begin
                        state <= COMMIT;
                        done  <= 1'b1;
                    end
                end
                COMMIT: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/display_scan_driver.sv
// Four-digit multiplexed 7448 driver: captures a binary count, converts it
// to BCD in the background and scans the digits with leading-zero blanking.
module display_scan_driver #(
    parameter int SCAN_DIV   = 1000,
    parameter int NUM_DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [display_pkg::VALUE_W-1:0] value,
    input  logic                          load,
    input  logic                          blank,
    input  logic                          lamp_test,
    output logic [3:0]                    data,
    output logic                          LT,
    output logic                          RBI,
    output logic                          BI,
    output logic [NUM_DIGITS-1:0]         digit_sel,
    output logic                          busy
);

    import display_pkg::*;

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(SCAN_DIV - 1);

    logic [BCD_W-1:0]   disp_reg;
    logic [BCD_W-1:0]   conv_bcd;
    logic               conv_done;
    logic               conv_start;
    logic [VALUE_W-1:0] value_sat;

    logic [DIV_W-1:0]   div_cnt;
    logic               div_tc;
    logic [1:0]         idx;
    logic [1:0]         idx_next;
    logic [3:0]         zero_d;
    logic [3:0]         rbi_vec;

    assign value_sat  = saturate(value);
    assign conv_start = load & ~busy;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (value_sat),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            disp_reg <= '0;
        end else begin
            if (conv_start)
                busy <= 1'b1;
            else if (conv_done)
                busy <= 1'b0;
            if (conv_done)
                disp_reg <= conv_bcd;
        end
    end

    // RBI for digit i is high when digit i and every digit above it are
    // zero; digit 0 never blanks so a zero count still shows "0".
    always_comb begin
        for (int i = 0; i < 4; i++)
            zero_d[i] = (disp_reg[4*i +: 4] == 4'd0);
        rbi_vec = {zero_d[3],
                   zero_d[3] & zero_d[2],
                   zero_d[3] & zero_d[2] & zero_d[1],
                   1'b0};
    end

    assign div_tc   = (div_cnt == DIV_TC);
    assign idx_next = div_tc ? idx + 2'd1 : idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            idx       <= '0;
            digit_sel <= NUM_DIGITS'(1);
            data      <= '0;
            RBI       <= 1'b0;
            BI        <= 1'b0;
            LT        <= 1'b0;
        end else begin
            div_cnt   <= div_tc ? '0 : div_cnt + 1'b1;
            idx       <= idx_next;
            digit_sel <= NUM_DIGITS'(1) << idx_next;
            data      <= disp_reg[{idx_next, 2'b00} +: 4];
            RBI       <= rbi_vec[idx_next];
            BI        <= blank;
            LT        <= lamp_test;
        end
    end

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed bench for display_scan_driver with SCAN_DIV=4: table of
// conversions plus hand sequences for reset, ignored loads, BI/LT and abort.
module tb_display_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] value;
    logic        load;
    logic        blank;
    logic        lamp_test;
    logic [3:0]  data;
    logic        LT;
    logic        RBI;
    logic        BI;
    logic [3:0]  digit_sel;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [15:0] cur_bcd = 16'h0000;

    typedef struct {
        logic [13:0] v;
        logic [15:0] bcd;
        logic [3:0]  rbi;
    } vec_t;

    vec_t vecs [13];

    display_scan_driver #(.SCAN_DIV(4), .NUM_DIGITS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .value     (value),
        .load      (load),
        .blank     (blank),
        .lamp_test (lamp_test),
        .data      (data),
        .LT        (LT),
        .RBI       (RBI),
        .BI        (BI),
        .digit_sel (digit_sel),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sel_idx(input logic [3:0] s);
        case (s)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic scan_check(input string tag, input logic [15:0] eb, input logic [3:0] er);
        int ix;
        logic [3:0] seen;
        seen = 4'b0000;
        for (int c = 0; c < 16; c++) begin
            tick();
            ix = sel_idx(digit_sel);
            seen |= digit_sel;
            if (ix < 0) begin
                chk({tag, " onehot"}, 32'(digit_sel), 32'h1);
            end else begin
                chk($sformatf("%s data d%0d", tag, ix), 32'(data), 32'(eb[ix*4 +: 4]));
                chk($sformatf("%s rbi d%0d", tag, ix), 32'(RBI), 32'(er[ix]));
            end
        end
        chk({tag, " all digits scanned"}, 32'(seen), 32'hF);
    endtask

    task automatic run_conv(input logic [13:0] v, input logic [15:0] eb, input logic [3:0] er,
                            input string tag);
        int n;
        int ix;
        value = v;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            ix = sel_idx(digit_sel);
            if (ix >= 0)
                chk({tag, " old display held"}, 32'(data), 32'(cur_bcd[ix*4 +: 4]));
            n++;
            tick();
        end
        chk({tag, " busy cycles"}, 32'(n), 32'd15);
        cur_bcd = eb;
        scan_check(tag, eb, er);
    endtask

    initial begin
        int n;
        int changes;
        logic [3:0] prev_sel;

        vecs[0]  = '{14'd1234,  16'h1234, 4'b0000};
        vecs[1]  = '{14'd12000, 16'h9999, 4'b0000};
        vecs[2]  = '{14'd42,    16'h0042, 4'b1100};
        vecs[3]  = '{14'd0,     16'h0000, 4'b1110};
        vecs[4]  = '{14'd9999,  16'h9999, 4'b0000};
        vecs[5]  = '{14'd10000, 16'h9999, 4'b0000};
        vecs[6]  = '{14'd16383, 16'h9999, 4'b0000};
        vecs[7]  = '{14'd1000,  16'h1000, 4'b0000};
        vecs[8]  = '{14'd100,   16'h0100, 4'b1000};
        vecs[9]  = '{14'd7,     16'h0007, 4'b1110};
        vecs[10] = '{14'd305,   16'h0305, 4'b1000};
        vecs[11] = '{14'd9000,  16'h9000, 4'b0000};
        vecs[12] = '{14'd9998,  16'h9998, 4'b0000};

        // Reset holds every output even with all inputs asserted.
        rst_n = 1'b0;
        value = 14'd1234;
        load = 1'b1;
        blank = 1'b1;
        lamp_test = 1'b1;
        repeat (3) tick();
        chk("reset data", 32'(data), 32'h0);
        chk("reset LT", 32'(LT), 32'h0);
        chk("reset RBI", 32'(RBI), 32'h0);
        chk("reset BI", 32'(BI), 32'h0);
        chk("reset digit_sel", 32'(digit_sel), 32'h1);
        chk("reset busy", 32'(busy), 32'h0);
        load = 1'b0;
        blank = 1'b0;
        lamp_test = 1'b0;
        rst_n = 1'b1;

        // Idle scan after reset: digit_sel advances every 4 cycles.
        for (int c = 1; c <= 16; c++) begin
            int e;
            tick();
            e = (c / 4) % 4;
            chk($sformatf("walk sel c%0d", c), 32'(digit_sel), 32'(4'b0001 << e));
            chk($sformatf("walk data c%0d", c), 32'(data), 32'h0);
            chk($sformatf("walk rbi c%0d", c), 32'(RBI), (e != 0) ? 32'h1 : 32'h0);
        end

        for (int i = 0; i < 13; i++)
            run_conv(vecs[i].v, vecs[i].bcd, vecs[i].rbi, $sformatf("vec%0d", i));

        // Second load five cycles into a conversion must be ignored.
        value = 14'd7;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (n == 5) begin
                value = 14'd55;
                load  = 1'b1;
            end else begin
                load  = 1'b0;
            end
            tick();
        end
        load = 1'b0;
        chk("ignore busy cycles", 32'(n), 32'd15);
        tick();
        chk("ignore stays idle", 32'(busy), 32'h0);
        cur_bcd = 16'h0007;
        scan_check("ignore", 16'h0007, 4'b1110);

        // blank to BI: one-cycle latency, scan keeps running.
        blank = 1'b1;
        chk("bi before latency", 32'(BI), 32'h0);
        changes = 0;
        prev_sel = digit_sel;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("bi high c%0d", c), 32'(BI), 32'h1);
            if (digit_sel != prev_sel) changes++;
            prev_sel = digit_sel;
        end
        blank = 1'b0;
        chk("scan runs while blanked", 32'(changes > 0), 32'h1);
        tick();
        chk("bi released", 32'(BI), 32'h0);

        lamp_test = 1'b1;
        chk("lt before latency", 32'(LT), 32'h0);
        tick();
        lamp_test = 1'b0;
        chk("lt pulse", 32'(LT), 32'h1);
        tick();
        chk("lt pulse end", 32'(LT), 32'h0);

        blank = 1'b1;
        lamp_test = 1'b1;
        tick();
        chk("both BI", 32'(BI), 32'h1);
        chk("both LT", 32'(LT), 32'h1);
        blank = 1'b0;
        lamp_test = 1'b0;
        tick();
        chk("both BI off", 32'(BI), 32'h0);
        chk("both LT off", 32'(LT), 32'h0);

        // Reset in the middle of a conversion discards it.
        value = 14'd9999;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        repeat (8) tick();
        chk("abort busy before reset", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'h0);
        chk("abort data", 32'(data), 32'h0);
        chk("abort digit_sel", 32'(digit_sel), 32'h1);
        repeat (2) tick();
        rst_n = 1'b1;
        cur_bcd = 16'h0000;
        scan_check("after abort", 16'h0000, 4'b1110);
        run_conv(14'd1, 16'h0001, 4'b1110, "reload 1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
